// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared FSM state type and register map for the interrupt controller.
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_CLAIM   = 2'd2;

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - register bus and interrupt line between CPU and controller.
interface interrupt_controller_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
);
  logic            reg_we;
  logic [1:0]      reg_addr;
  logic [31:0]     reg_wdata;
  logic [31:0]     reg_rdata;
  logic            irq;
  logic [ID_W-1:0] irq_id;

  modport master (
    output reg_we, reg_addr, reg_wdata,
    input  reg_rdata, irq, irq_id
  );

  modport slave (
    input  reg_we, reg_addr, reg_wdata,
    output reg_rdata, irq, irq_id
  );
endinterface

// File: rtl/intc_arbiter.sv
// rtl/intc_arbiter.sv - combinational winner select; INTC_RR_EN selects round-robin over fixed priority.
module intc_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
`ifdef INTC_RR_EN
  input  logic [ID_W-1:0]    last_id,
`endif
  output logic [ID_W-1:0]    win_id,
  output logic               valid
);

`ifdef INTC_RR_EN
  always_comb begin
    int idx;
    idx    = 0;
    win_id = '0;
    valid  = 1'b0;
    // search begins just after the previous grant and wraps around
    for (int off = 1; off <= NUM_SRC; off++) begin
      idx = (int'(last_id) + off) % NUM_SRC;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end
`else
  always_comb begin
    win_id = '0;
    valid  = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid  = 1'b1;
        win_id = ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-triggered interrupt controller with MASK/PENDING/CLAIM registers.
// Define INTC_RR_EN for round-robin arbitration; default build uses fixed lowest-index priority.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_req,
  interrupt_controller_if.slave  bus
);

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] evt_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_clr;
  logic               armed;
  state_t             state;
  logic               irq_r;
  logic [ID_W-1:0]    id_r;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic               wr_mask;
  logic               wr_pending;
  logic               claim_hit;
  logic               unused_wdata;

  assign wr_mask    = bus.reg_we && (bus.reg_addr == ADDR_MASK);
  assign wr_pending = bus.reg_we && (bus.reg_addr == ADDR_PENDING);
  assign claim_hit  = bus.reg_we && (bus.reg_addr == ADDR_CLAIM) &&
                      (state == ST_ASSERT) && (bus.reg_wdata[ID_W-1:0] == id_r);
  assign unused_wdata = ^bus.reg_wdata[31:NUM_SRC];

  always_comb begin
    pending_clr = '0;
    if (wr_pending) pending_clr = bus.reg_wdata[NUM_SRC-1:0];
    if (claim_hit)  pending_clr = pending_clr | (NUM_SRC'(1) << id_r);
  end

  // armed stays low for the first cycle after reset so lines held high are not seen as edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q   <= '0;
      evt_q   <= '0;
      armed   <= 1'b0;
      mask    <= '0;
      pending <= '0;
    end else begin
      src_q   <= src_req;
      evt_q   <= armed ? (src_req & ~src_q) : '0;
      armed   <= 1'b1;
      pending <= (pending & ~pending_clr) | evt_q;
      if (wr_mask) mask <= bus.reg_wdata[NUM_SRC-1:0];
    end
  end

`ifdef INTC_RR_EN
  logic [ID_W-1:0] last_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              last_id <= ID_W'(NUM_SRC - 1);
    else if (state == ST_IDLE && win_valid) last_id <= win_id;
  end
`endif

  intc_arbiter #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_arbiter (
    .req     (pending & mask),
`ifdef INTC_RR_EN
    .last_id (last_id),
`endif
    .win_id  (win_id),
    .valid   (win_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      irq_r <= 1'b0;
      id_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state <= ST_ASSERT;
            irq_r <= 1'b1;
            id_r  <= win_id;
          end
        end
        ST_ASSERT: begin
          if (claim_hit) begin
            state <= ST_GAP;
            irq_r <= 1'b0;
          end else if (!mask[id_r]) begin
            state <= ST_IDLE;
            irq_r <= 1'b0;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          irq_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq    = irq_r;
  assign bus.irq_id = id_r;

  always_comb begin
    bus.reg_rdata = 32'h0;
    case (bus.reg_addr)
      ADDR_MASK:    bus.reg_rdata = {{(32-NUM_SRC){1'b0}}, mask};
      ADDR_PENDING: bus.reg_rdata = {{(32-NUM_SRC){1'b0}}, pending};
      ADDR_CLAIM:   bus.reg_rdata = (state == ST_ASSERT) ? {{(32-ID_W){1'b0}}, id_r} : 32'hFFFF_FFFF;
      default:      bus.reg_rdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard bench for interrupt_controller (honours INTC_RR_EN).
module tb_interrupt_controller;
  import intc_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int ID_W    = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NUM_SRC-1:0] src_req = '0;
  int                 total = 0;
  int                 bad = 0;
  int                 exp_q[$];
  int                 last_grant = NUM_SRC - 1;

  interrupt_controller_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

  interrupt_controller #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .src_req (src_req),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    bus.reg_we    = 1'b1;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    tick();
    bus.reg_we    = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    bus.reg_addr = a;
    #1;
    d = bus.reg_rdata;
  endtask

  function automatic int pick(input logic [NUM_SRC-1:0] p, input int last);
    int w;
    w = -1;
`ifdef INTC_RR_EN
    for (int off = 1; off <= NUM_SRC; off++)
      if (w < 0 && p[(last + off) % NUM_SRC]) w = (last + off) % NUM_SRC;
`else
    for (int i = 0; i < NUM_SRC; i++)
      if (w < 0 && p[i]) w = i;
`endif
    return w;
  endfunction

  task automatic check_grant(input string name);
    int e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected irq_id=%0d with empty scoreboard", name, bus.irq_id);
    end else begin
      e = exp_q.pop_front();
      last_grant = e;
      if (bus.irq_id !== ID_W'(e)) begin
        bad++;
        $display("FAIL %s irq_id got=%0d exp=%0d", name, bus.irq_id, e);
      end
    end
  endtask

  task automatic wait_irq(input string name);
    int n;
    n = 0;
    while (bus.irq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.irq !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s irq timeout got=%b exp=1", name, bus.irq);
    end else begin
      check_grant(name);
    end
  endtask

  task automatic claim(input int id);
    reg_write(ADDR_CLAIM, 32'(id));
    total++;
    if (bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL claim_drop id=%0d irq got=%b exp=0", id, bus.irq);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    total++;
    if (bus.irq !== 1'b0 || bus.irq_id !== '0) begin
      bad++;
      $display("FAIL reset_outputs irq=%b irq_id=%0d exp 0/0", bus.irq, bus.irq_id);
    end
    reg_read(ADDR_MASK, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", d); end
    reg_read(ADDR_PENDING, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_pending got=%h exp=0", d); end
    reg_read(ADDR_CLAIM, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_claim got=%h exp=ffffffff", d); end
    reg_read(2'd3, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL addr3_read got=%h exp=0", d); end
    rst = 1'b1;
    tick();
    last_grant = NUM_SRC - 1;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    reg_write(ADDR_MASK, 32'hF);
    src_req[2] = 1'b1;
    exp_q.push_back(2);
    tick();
    tick();
    reg_read(ADDR_PENDING, d);
    total++;
    if (d !== 32'h4 || bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL basic_pending pending=%h irq=%b exp 4/0", d, bus.irq);
    end
    tick();
    src_req[2] = 1'b0;
    total++;
    if (bus.irq !== 1'b1) begin bad++; $display("FAIL basic_latency irq got=%b exp=1", bus.irq); end
    check_grant("basic_id");
    reg_read(ADDR_CLAIM, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL basic_claim_read got=%h exp=2", d); end
    claim(2);
    reg_read(ADDR_PENDING, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL basic_pending_clr got=%h exp=0", d); end
    reg_read(ADDR_CLAIM, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL gap_claim_read got=%h exp=ffffffff", d); end
    tick();
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL basic_idle irq got=%b exp=0", bus.irq); end
  endtask

  task automatic test_priority();
    logic [NUM_SRC-1:0] p;
    int first;
    int second;
    p = 4'b1010;
    first = pick(p, last_grant);
    p[first] = 1'b0;
    second = pick(p, first);
    exp_q.push_back(first);
    exp_q.push_back(second);
    src_req = 4'b1010;
    tick();
    src_req = '0;
    wait_irq("prio_first");
    claim(first);
    wait_irq("prio_second");
    claim(second);
  endtask

  task automatic test_mismatch_mask();
    logic [31:0] d;
    src_req[0] = 1'b1;
    exp_q.push_back(0);
    tick();
    src_req[0] = 1'b0;
    wait_irq("mm_assert");
    reg_write(ADDR_CLAIM, 32'h1);
    total++;
    if (bus.irq !== 1'b1 || bus.irq_id !== 2'd0) begin
      bad++;
      $display("FAIL claim_mismatch irq=%b irq_id=%0d exp 1/0", bus.irq, bus.irq_id);
    end
    reg_write(ADDR_MASK, 32'hE);
    tick();
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL mask_drop irq got=%b exp=0", bus.irq); end
    reg_read(ADDR_PENDING, d);
    total++;
    if (d[0] !== 1'b1) begin bad++; $display("FAIL mask_keeps_pending got=%h exp bit0=1", d); end
    reg_write(ADDR_MASK, 32'hF);
    exp_q.push_back(0);
    wait_irq("mm_reassert");
    claim(0);
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    src_req[0] = 1'b1;
    exp_q.push_back(0);
    tick();
    src_req[0] = 1'b0;
    wait_irq("sw_assert");
    src_req[0] = 1'b1;
    tick();
    reg_write(ADDR_CLAIM, 32'h0);
    src_req[0] = 1'b0;
    reg_read(ADDR_PENDING, d);
    total++;
    if (d[0] !== 1'b1 || bus.irq !== 1'b0) begin
      bad++;
      $display("FAIL set_wins pending=%h irq=%b exp bit0=1 irq=0", d, bus.irq);
    end
    exp_q.push_back(0);
    wait_irq("sw_reassert");
    claim(0);
    reg_read(ADDR_PENDING, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL sw_final_pending got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid_assert();
    logic [31:0] d;
    logic        seen;
    src_req[1] = 1'b1;
    exp_q.push_back(1);
    wait_irq("rm_assert");
    rst = 1'b0;
    #2;
    total++;
    if (bus.irq !== 1'b0) begin bad++; $display("FAIL async_reset irq got=%b exp=0", bus.irq); end
    reg_read(ADDR_PENDING, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_loses_pending got=%h exp=0", d); end
    tick();
    tick();
    rst = 1'b1;
    last_grant = NUM_SRC - 1;
    reg_write(ADDR_MASK, 32'hF);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.irq !== 1'b0) seen = 1'b1;
      tick();
    end
    reg_read(ADDR_PENDING, d);
    total++;
    if (seen !== 1'b0 || d !== 32'h0) begin
      bad++;
      $display("FAIL held_high_no_event irq_seen=%b pending=%h exp 0/0", seen, d);
    end
    src_req[1] = 1'b0;
    tick();
    src_req[1] = 1'b1;
    exp_q.push_back(1);
    tick();
    src_req[1] = 1'b0;
    wait_irq("rm_new_edge");
    claim(1);
  endtask

  initial begin
    bus.reg_we    = 1'b0;
    bus.reg_addr  = 2'd0;
    bus.reg_wdata = 32'h0;
    #12;
    test_reset();
    test_basic();
    test_priority();
    test_mismatch_mask();
    test_set_wins();
    test_reset_mid_assert();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
